// File: rtl/ahb_decoder_mux.sv
// ahb_decoder_mux: AHB address decode, registered response mux, default slave and wait-state watchdog
module ahb_decoder_mux #(
   parameter logic [31:0] S0_BASE = 32'h0000_0000,
   parameter logic [31:0] S0_MASK = 32'hFFFF_F000,
   parameter logic [31:0] S1_BASE = 32'h0000_1000,
   parameter logic [31:0] S1_MASK = 32'hFFFF_F000,
   parameter logic [31:0] S2_BASE = 32'h0000_2000,
   parameter logic [31:0] S2_MASK = 32'hFFFF_F000,
   parameter int TIMEOUT = 16,
   parameter int W_CNT = 16
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   output logic        o_HSEL_s0,
   output logic        o_HSEL_s1,
   output logic        o_HSEL_s2,
   input  logic [31:0] s0_HRDATA,
   input  logic [31:0] s1_HRDATA,
   input  logic [31:0] s2_HRDATA,
   input  logic [1:0]  s0_HRESP,
   input  logic [1:0]  s1_HRESP,
   input  logic [1:0]  s2_HRESP,
   input  logic        s0_HREADY,
   input  logic        s1_HREADY,
   input  logic        s2_HREADY,
   output logic [31:0] o_HRDATA,
   output logic [1:0]  o_HRESP,
   output logic        o_HREADY,
   input  logic        i_timeout_clr,
   output logic        o_timeout_flag
);
   typedef enum logic [1:0] {FWD, ERR1, ERR2} state_t;
   localparam logic [1:0] SEL_S0 = 2'd0, SEL_S1 = 2'd1, SEL_S2 = 2'd2, SEL_DEF = 2'd3;
   state_t            state, nxt;
   logic [1:0]        a_sel, d_sel, s_resp;
   logic              d_act, m0, m1, m2, s_ready, wait_st, abort, unused_trans0;
   logic [31:0]       s_rdata;
   logic [W_CNT-1:0]  cnt;
   assign m0 = (HADDR & S0_MASK) == S0_BASE;
   assign m1 = (HADDR & S1_MASK) == S1_BASE;
   assign m2 = (HADDR & S2_MASK) == S2_BASE;
   assign o_HSEL_s0 = m0;
   assign o_HSEL_s1 = !m0 && m1;
   assign o_HSEL_s2 = !m0 && !m1 && m2;
   assign a_sel = m0 ? SEL_S0 : m1 ? SEL_S1 : m2 ? SEL_S2 : SEL_DEF;
   assign unused_trans0 = HTRANS[0];
   assign s_ready = d_sel == SEL_S0 ? s0_HREADY : d_sel == SEL_S1 ? s1_HREADY : d_sel == SEL_S2 ? s2_HREADY : 1'b1;
   assign s_resp  = d_sel == SEL_S0 ? s0_HRESP  : d_sel == SEL_S1 ? s1_HRESP  : d_sel == SEL_S2 ? s2_HRESP  : 2'b00;
   assign s_rdata = d_sel == SEL_S0 ? s0_HRDATA : d_sel == SEL_S1 ? s1_HRDATA : d_sel == SEL_S2 ? s2_HRDATA : 32'd0;
   assign wait_st = state == FWD && d_act && d_sel != SEL_DEF && !s_ready;
   assign abort = TIMEOUT != 0 && wait_st && cnt == W_CNT'(TIMEOUT - 1);
   // response selection and error sequencing; the first ERROR cycle is driven straight from FWD
   always_comb begin
      nxt = state;
      o_HREADY = s_ready;
      o_HRESP = s_resp;
      o_HRDATA = s_rdata;
      if (state == ERR2) begin
         o_HREADY = 1'b1;
         o_HRESP = 2'b01;
         o_HRDATA = 32'd0;
         nxt = FWD;
      end else if (state == ERR1 || (d_sel == SEL_DEF && d_act) || abort) begin
         o_HREADY = 1'b0;
         o_HRESP = 2'b01;
         o_HRDATA = 32'd0;
         nxt = ERR2;
      end
   end
   // state, data-phase target, watchdog count and sticky abort flag
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state <= FWD;
         d_sel <= SEL_DEF;
         d_act <= 1'b0;
         cnt <= '0;
         o_timeout_flag <= 1'b0;
      end else begin
         state <= nxt;
         if (o_HREADY && state != ERR1) begin
            d_sel <= a_sel;
            d_act <= HTRANS[1];
         end
         cnt <= o_HREADY ? '0 : (wait_st && cnt != '1) ? cnt + 1'b1 : cnt;
         o_timeout_flag <= abort || (o_timeout_flag && !i_timeout_clr);
      end
   end
endmodule
